// File: rtl/cpu_trace_fifo.sv
// -----------------------------------------------------------------------------
// cpu_trace_fifo
// Trace-capture stage that sits behind the 16-bit single-cycle mips core.
// After an optional PC trigger it samples the core's {pc, alu} pair once per
// clock into a circular first-word-fall-through FIFO. The FIFO drains over a
// valid/ready port. Entries that arrive while the FIFO is full are dropped,
// and each drop is counted in a saturating overflow counter.
//
// Ports
//   clk        core clock, rising edge
//   rst        asynchronous active-low reset (0 = reset)
//   cpu_run    1 = core executing; capture pauses while 0
//   pc_in      core pc_out
//   alu_in     core alu_out
//   arm        level; 1 = trace armed, 0 = return to IDLE
//   trig_en    1 = wait for pc_in == trig_pc, 0 = capture immediately
//   trig_pc    trigger address
//   out_valid  head entry available
//   out_ready  consumer accepts the head when out_valid & out_ready
//   out_pc     head pc field, 0 when empty
//   out_alu    head alu field, 0 when empty
//   count      entries held, 0..DEPTH
//   ovf_cnt    dropped entries, saturates at 255
//   state      0 IDLE, 1 ARMED, 2 CAPTURE
// -----------------------------------------------------------------------------
module cpu_trace_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_run,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic              arm,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_alu,
  output logic [AW:0]       count,
  output logic [7:0]        ovf_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam int            EW       = 2 * DATA_W;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                trig_hit_s;
  logic                push_req_s;
  logic                pop_s;
  logic                full_s;
  logic                wr_en_s;
  logic                drop_s;
  logic                arm_start_s;
  logic [AW-1:0]       wr_r;
  logic [AW-1:0]       rd_r;
  logic [AW-1:0]       wr_nxt_s;
  logic [AW-1:0]       rd_nxt_s;
  logic [AW:0]         count_r;
  logic [AW:0]         count_nxt_s;
  logic [7:0]          ovf_r;
  logic [7:0]          ovf_nxt_s;
  logic [EW-1:0]       push_data_s;
  logic [EW-1:0]       head_nxt_s;
  logic [EW-1:0]       head_r;
  logic                valid_r;
  logic [EW-1:0]       mem_r [DEPTH];

  assign push_data_s = {pc_in, alu_in};

  // Trigger match and FIFO push/pop/drop decode
  always_comb begin
    trig_hit_s  = (!trig_en) || (pc_in == trig_pc);
    // The ARMED->CAPTURE edge captures the trigger sample itself.
    push_req_s  = arm && cpu_run &&
                  ((state_r == ST_CAPTURE) || ((state_r == ST_ARMED) && trig_hit_s));
    pop_s       = valid_r && out_ready;
    full_s      = (count_r == FULL_CNT);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    wr_en_s     = push_req_s && ((!full_s) || pop_s);
    drop_s      = push_req_s && full_s && (!pop_s);
    arm_start_s = (state_r == ST_IDLE) && arm;
  end

  // FSM next-state; arm=0 forces IDLE from any state
  always_comb begin
    state_nxt_s = state_r;
    if (!arm) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_ARMED;
        end
        ST_ARMED: begin
          if (cpu_run && trig_hit_s) begin
            state_nxt_s = ST_CAPTURE;
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end
        ST_CAPTURE: begin
          state_nxt_s = ST_CAPTURE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Next pointers, occupancy and overflow counter
  always_comb begin
    wr_nxt_s    = wr_r;
    rd_nxt_s    = rd_r;
    count_nxt_s = count_r;
    ovf_nxt_s   = ovf_r;
    if (wr_en_s) begin
      wr_nxt_s = wr_r + PTR_ONE;
    end else begin
      wr_nxt_s = wr_r;
    end
    if (pop_s) begin
      rd_nxt_s = rd_r + PTR_ONE;
    end else begin
      rd_nxt_s = rd_r;
    end
    case ({wr_en_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    if (arm_start_s) begin
      ovf_nxt_s = 8'd0;
    end else if (drop_s && (ovf_r != 8'hFF)) begin
      ovf_nxt_s = ovf_r + 8'd1;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // Next head entry for the registered FWFT output
  always_comb begin
    head_nxt_s = '0;
    if (count_nxt_s == CNT_ZERO) begin
      head_nxt_s = '0;
    end else if (wr_en_s && (rd_nxt_s == wr_r)) begin
      // New head is the slot being written this edge; memory not yet updated.
      head_nxt_s = push_data_s;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // State, pointer, counter and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      wr_r    <= '0;
      rd_r    <= '0;
      count_r <= '0;
      ovf_r   <= 8'd0;
      valid_r <= 1'b0;
      head_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      wr_r    <= wr_nxt_s;
      rd_r    <= rd_nxt_s;
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
      valid_r <= (count_nxt_s != CNT_ZERO);
      head_r  <= head_nxt_s;
    end
  end

  // Trace storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_r] <= push_data_s;
    end
  end

  assign out_valid = valid_r;
  assign out_pc    = head_r[EW-1:DATA_W];
  assign out_alu   = head_r[DATA_W-1:0];
  assign count     = count_r;
  assign ovf_cnt   = ovf_r;
  assign state     = state_r;

endmodule

// File: tb/tb_cpu_trace_fifo.sv
// -----------------------------------------------------------------------------
// tb_cpu_trace_fifo
// Self-checking bench for cpu_trace_fifo. A small behavioural model tracks the
// FSM state, the overflow counter and a scoreboard queue of captured entries.
// Expected entries are pushed when capture stimulus is driven and are popped
// and compared whenever the consumer accepts the head.
// -----------------------------------------------------------------------------
module tb_cpu_trace_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_run;
  logic [15:0] pc_in;
  logic [15:0] alu_in;
  logic        arm;
  logic        trig_en;
  logic [15:0] trig_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [15:0] out_alu;
  logic [4:0]  count;
  logic [7:0]  ovf_cnt;
  logic [1:0]  state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_q[$];
  int          m_state = 0;
  int          m_ovf   = 0;
  logic [15:0] pc_seq  = 16'd0;

  cpu_trace_fifo #(.DATA_W(16), .DEPTH(16), .AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_run   (cpu_run),
    .pc_in     (pc_in),
    .alu_in    (alu_in),
    .arm       (arm),
    .trig_en   (trig_en),
    .trig_pc   (trig_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_alu   (out_alu),
    .count     (count),
    .ovf_cnt   (ovf_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [15:0] p);
    return {p, p ^ 16'h5A3C};
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 32'd0;
    check_val({tag, "_state"}, {30'd0, state}, m_state);
    check_val({tag, "_count"}, {27'd0, count}, m_q.size());
    check_val({tag, "_valid"}, {31'd0, out_valid}, (m_q.size() > 0) ? 32'd1 : 32'd0);
    check_val({tag, "_head"}, {out_pc, out_alu}, head);
    check_val({tag, "_ovf"}, {24'd0, ovf_cnt}, m_ovf);
  endtask

  task automatic drive_pc(input logic [15:0] p);
    pc_in  = p;
    alu_in = p ^ 16'h5A3C;
  endtask

  // One clock: predict the edge from the inputs, then compare after it.
  task automatic tick();
    logic [31:0] popped;
    bit          pop;
    bit          push;
    bit          full;
    bit          hit;
    full = (m_q.size() == 16);
    pop  = (m_q.size() > 0) && out_ready;
    hit  = (!trig_en) || (pc_in == trig_pc);
    push = arm && cpu_run && ((m_state == 2) || ((m_state == 1) && hit));
    if (pop) begin
      popped = m_q.pop_front();
      check_val("pop_entry", {out_pc, out_alu}, popped);
    end
    if (push) begin
      if (!full || pop) m_q.push_back({pc_in, alu_in});
      else if (m_ovf < 255) m_ovf++;
    end
    if (!arm) m_state = 0;
    else if (m_state == 0) begin
      m_state = 1;
      m_ovf   = 0;
    end else if (m_state == 1 && cpu_run && hit) m_state = 2;
    @(posedge clk);
    @(negedge clk);
    check_all("cyc");
  endtask

  task automatic cap(input int n);
    for (int i = 0; i < n; i++) begin
      drive_pc(pc_seq);
      tick();
      pc_seq = pc_seq + 16'd1;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && count != 5'd0; i++) tick();
    out_ready = 1'b0;
    check_val("drain_empty", {27'd0, count}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; cpu_run = 1'b0; arm = 1'b0; trig_en = 1'b0;
    trig_pc = 16'd0; out_ready = 1'b0; drive_pc(16'd0);
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Immediate capture, 3 samples, then step the head out with ready pulses
    arm = 1'b1;
    tick();
    cpu_run = 1'b1;
    pc_seq  = 16'd0;
    cap(3);
    check_val("t2_count", {27'd0, count}, 32'd3);
    arm = 1'b0; cpu_run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("t2_head", {16'd0, out_pc}, i);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
    end

    // PC trigger at 0x0006 while pc walks 0..9
    arm = 1'b1;
    tick();
    trig_en = 1'b1; trig_pc = 16'h0006; cpu_run = 1'b1;
    pc_seq  = 16'd0;
    cap(10);
    check_val("t3_first", {16'd0, out_pc}, 32'h6);
    check_val("t3_count", {27'd0, count}, 32'd4);
    arm = 1'b0; cpu_run = 1'b0; trig_en = 1'b0;
    drain();

    // Overflow: 20 samples into 16 entries
    arm = 1'b1;
    tick();
    cpu_run = 1'b1;
    pc_seq  = 16'd100;
    cap(20);
    check_val("t4_count", {27'd0, count}, 32'd16);
    check_val("t4_ovf", {24'd0, ovf_cnt}, 32'd4);
    check_val("t4_head", {out_pc, out_alu}, mk(16'd100));

    // Full with simultaneous push and pop: no drops
    out_ready = 1'b1;
    cap(5);
    out_ready = 1'b0;
    check_val("t5_count", {27'd0, count}, 32'd16);
    check_val("t5_ovf", {24'd0, ovf_cnt}, 32'd4);
    check_val("t5_head", {16'd0, out_pc}, 32'd105);

    // Overflow counter saturates
    cap(260);
    check_val("ovf_sat", {24'd0, ovf_cnt}, 32'd255);
    arm = 1'b0; cpu_run = 1'b0;
    tick();
    drain();

    // Re-arm clears ovf; capture 7 with a core pause, then disarm and drain
    arm = 1'b1;
    tick();
    check_val("rearm_ovf", {24'd0, ovf_cnt}, 32'd0);
    cpu_run = 1'b1;
    pc_seq  = 16'd200;
    cap(3);
    cpu_run = 1'b0;
    cap(2);
    cpu_run = 1'b1;
    cap(4);
    check_val("t6_count", {27'd0, count}, 32'd7);
    arm = 1'b0;
    cap(1);
    check_val("t6_idle", {30'd0, state}, 32'd0);
    check_val("t6_hold", {27'd0, count}, 32'd7);
    cap(2);
    check_val("t6_hold2", {27'd0, count}, 32'd7);
    cpu_run = 1'b0;
    drain();

    // Asynchronous reset mid-capture, away from any clock edge
    arm = 1'b1;
    tick();
    cpu_run = 1'b1;
    cap(5);
    #($urandom_range(1, 3));
    rst = 1'b0;
    m_q.delete();
    m_state = 0;
    m_ovf   = 0;
    #1;
    check_all("async_rst");
    check_val("async_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_all("rst_hold");
    arm = 1'b0; cpu_run = 1'b0;
    rst = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
